// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM sequencing fetch/decode/execute/memory/writeback
//
// Purpose: multi-cycle core sequencer. Issues instruction-fetch and data-memory
// requests, IR/PC/register-file strobes, counts retired instructions and halts
// on a decoder panic, an illegal state or a memory timeout.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   imem_ready, dmem_ready          memory handshake completions
//   alu_operation .. panic          decoder flags
//   branch_taken                    ALU compare result (valid in EXECUTE)
//   imem_req, ir_write              fetch request / IR load
//   dmem_req, dmem_we               data request / store
//   rf_write, wb_sel                register write enable / source (1 = memory)
//   pc_write, pc_sel                PC update / source (1 = target)
//   state, halted, halt_cause       FSM state and halt status
//   retired_count                   retired-instruction counter
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  logic               alu_operation,
    input  logic               write_register,
    input  logic               load_word_memory,
    input  logic               store_word_memory,
    input  logic               branch,
    input  logic               jump,
    input  logic               panic,
    input  logic               branch_taken,
    output logic               imem_req,
    output logic               ir_write,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic               rf_write,
    output logic               wb_sel,
    output logic               pc_write,
    output logic               pc_sel,
    output logic [2:0]         state,
    output logic               halted,
    output logic [1:0]         halt_cause,
    output logic [COUNT_W-1:0] retired_count
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               take_q, take_d;
    logic               is_load_q, is_load_d;
    logic               is_store_q, is_store_d;
    logic [1:0]         halt_cause_q, halt_cause_d;
    logic [COUNT_W-1:0] retired_count_q, retired_count_d;

    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        take_d          = take_q;
        is_load_d       = is_load_q;
        is_store_d      = is_store_q;
        halt_cause_d    = halt_cause_q;
        retired_count_d = retired_count_q;
        case (state_q)
            S_FETCH: begin
                // Ready on the limit cycle wins over the timeout.
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d      = S_HALT;
                    halt_cause_d = 2'b10;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (panic) begin
                    state_d      = S_HALT;
                    halt_cause_d = 2'b01;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                take_d     = jump | (branch & branch_taken);
                is_load_d  = load_word_memory;
                // Load wins when the decoder flags both.
                is_store_d = store_word_memory & ~load_word_memory;
                if (load_word_memory | store_word_memory) begin
                    state_d    = S_MEMORY;
                    wait_cnt_d = '0;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (dmem_ready) begin
                    state_d = S_WRITEBACK;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d      = S_HALT;
                    halt_cause_d = 2'b11;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_WRITEBACK: begin
                retired_count_d = retired_count_q + 1'b1;
                state_d         = S_FETCH;
                wait_cnt_d      = '0;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d      = S_HALT;
                halt_cause_d = 2'b01;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_FETCH;
            wait_cnt_q      <= '0;
            take_q          <= 1'b0;
            is_load_q       <= 1'b0;
            is_store_q      <= 1'b0;
            halt_cause_q    <= 2'b00;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            take_q          <= take_d;
            is_load_q       <= is_load_d;
            is_store_q      <= is_store_d;
            halt_cause_q    <= halt_cause_d;
            retired_count_q <= retired_count_d;
        end
    end

    // Every output is masked while reset is high, so nothing is written
    // during the reset cycle even if it lands mid-instruction.
    always_comb begin
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        rf_write      = 1'b0;
        wb_sel        = 1'b0;
        pc_write      = 1'b0;
        pc_sel        = 1'b0;
        state         = 3'd0;
        halted        = 1'b0;
        halt_cause    = 2'b00;
        retired_count = '0;
        if (!reset) begin
            state         = state_q;
            halt_cause    = halt_cause_q;
            retired_count = retired_count_q;
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                S_MEMORY: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store_q;
                end
                S_WRITEBACK: begin
                    rf_write = write_register & ~is_store_q;
                    wb_sel   = is_load_q;
                    pc_write = 1'b1;
                    pc_sel   = take_q;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
